// File: rtl/fc_requant_argmax.sv
// Collects OUT post-ReLU neuron results per frame. Each result is requantized
// (shift + saturate) into y[] while a running argmax tracks the raw maximum.

module fc_requant_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module fc_requant_argmax #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT   = 10,
  parameter int SHIFT = 7,
  localparam int ACC_W = WIDTH*2 + $clog2(IN),
  localparam int IDX_W = $clog2(OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y [0:OUT-1],
  output logic [IDX_W-1:0] max_idx,
  output logic [ACC_W-1:0] max_val
);
  typedef enum logic {COLLECT, HOLD} state_t;

  localparam int unsigned       SAT_I = (1 << (WIDTH-1)) - 1;
  localparam logic [ACC_W-1:0]  SAT_A = ACC_W'(SAT_I);
  localparam logic [WIDTH-1:0]  SAT_W = WIDTH'(SAT_I);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(OUT-1);

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [ACC_W-1:0] max_val_q;

  logic             accept;
  logic [ACC_W-1:0] shifted;
  logic [WIDTH-1:0] yq_d;

  // Beats arriving alongside clr are dropped, so slots must not capture them.
  assign accept  = in_valid && in_ready_q && !clr;
  assign shifted = in_data >> SHIFT;
  assign yq_d    = (shifted > SAT_A) ? SAT_W : shifted[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      max_idx_q   <= '0;
      max_val_q   <= '0;
    end else if (clr) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (accept) begin
          // First beat loads unconditionally; later beats need a strict win.
          if (cnt_q == '0 || in_data > max_val_q) begin
            max_val_q <= in_data;
            max_idx_q <= cnt_q;
          end
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            state_q     <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  for (genvar i = 0; i < OUT; i++) begin : g_slot
    fc_requant_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .we_i (accept && cnt_q == IDX_W'(i)),
      .d_i  (yq_d),
      .q_o  (y[i])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign max_idx   = max_idx_q;
  assign max_val   = max_val_q;
endmodule

// File: tb/tb_fc_requant_argmax.sv
// Directed bench for fc_requant_argmax with hand-computed expectations.

module tb_fc_requant_argmax;
  localparam int ACC_W = 23;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [ACC_W-1:0] in_data;
  logic [7:0]       y [0:9];
  logic [3:0]       max_idx;
  logic [ACC_W-1:0] max_val;

  int n_cmp = 0;
  int n_bad = 0;

  fc_requant_argmax dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .max_idx(max_idx), .max_val(max_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat for one edge, then sample 1ns after that edge.
  task automatic beat(input logic [ACC_W-1:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [7:0]       y3_hold;
  logic [ACC_W-1:0] mv_hold;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_max_idx", max_idx, 0);
    check("rst_max_val", max_val, 0);
    check("rst_y0", y[0], 0);
    check("rst_y9", y[9], 0);
    // beat while rst is high must be ignored
    in_valid = 1'b1; in_data = 23'd5000;
    @(posedge clk); #1;
    check("rst_no_accept", y[0], 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Frame A: i*256 -> y=2i, max at 9
    for (int i = 0; i < 10; i++) begin
      beat(ACC_W'(i*256));
      if (i == 8) check("A_no_early_valid", out_valid, 0);
    end
    check("A_out_valid", out_valid, 1);
    check("A_in_ready", in_ready, 0);
    check("A_y0", y[0], 0);
    check("A_y5", y[5], 10);
    check("A_y9", y[9], 18);
    check("A_max_idx", max_idx, 9);
    check("A_max_val", max_val, 2304);

    // Stall in HOLD with in_valid asserted
    y3_hold = y[3]; mv_hold = max_val;
    in_valid = 1'b1; in_data = 23'd77777;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k % 5 == 0) begin
        check("H_in_ready", in_ready, 0);
        check("H_out_valid", out_valid, 1);
        check("H_y3", y[3], 6);
        check("H_max_val", max_val, 2304);
      end
    end
    check("H_y3_stable", y[3], y3_hold);
    check("H_mv_stable", max_val, mv_hold);
    pop();  // in_valid still high here: must not be taken
    in_valid = 1'b0;
    check("P_out_valid", out_valid, 0);
    check("P_in_ready", in_ready, 1);
    check("P_y0_kept", y[0], 0);

    // Frame B: ties keep lowest index
    beat(23'd5000); beat(23'd300); beat(23'd5000);
    for (int i = 3; i < 10; i++) beat(23'd0);
    check("B_out_valid", out_valid, 1);
    check("B_y0", y[0], 39);
    check("B_y1", y[1], 2);
    check("B_y2", y[2], 39);
    check("B_y3", y[3], 0);
    check("B_max_idx", max_idx, 0);
    check("B_max_val", max_val, 5000);
    pop();

    // Frame C: saturation boundaries
    for (int i = 0; i < 10; i++) begin
      case (i)
        4: beat(23'h7FFFFF);
        7: beat(23'd16383);
        8: beat(23'd16384);
        9: beat(23'd16255);
        default: beat(23'd1);
      endcase
    end
    check("C_y0", y[0], 0);
    check("C_y4_sat", y[4], 127);
    check("C_y7_edge", y[7], 127);
    check("C_y8_sat", y[8], 127);
    check("C_y9", y[9], 126);
    check("C_max_idx", max_idx, 4);
    check("C_max_val", max_val, 23'h7FFFFF);
    pop();

    // Clear after 6 beats; the beat alongside clr is dropped
    for (int i = 0; i < 6; i++) beat(23'd100000);
    clr = 1'b1; in_valid = 1'b1; in_data = 23'd8000000;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("K_out_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      beat(ACC_W'((i+1)*128));
      if (i == 8) check("K_no_early_valid", out_valid, 0);
    end
    check("K_out_valid_end", out_valid, 1);
    check("K_y0", y[0], 1);
    check("K_y6", y[6], 7);
    check("K_max_idx", max_idx, 9);
    check("K_max_val", max_val, 1280);

    // clr and out_ready together in HOLD
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; out_ready = 1'b0;
    check("KR_out_valid", out_valid, 0);
    check("KR_in_ready", in_ready, 1);

    // Async reset mid-frame at cnt=3
    beat(23'd900); beat(23'd900); beat(23'd900);
    #2 rst = 1'b1;
    #1;
    check("R1_out_valid", out_valid, 0);
    check("R1_in_ready", in_ready, 1);
    check("R1_max_val", max_val, 0);
    check("R1_y0", y[0], 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) beat(ACC_W'(1000 - i));
    check("R1_frame_valid", out_valid, 1);
    check("R1_frame_y0", y[0], 7);
    check("R1_frame_idx", max_idx, 0);
    check("R1_frame_val", max_val, 1000);

    // Async reset mid-HOLD
    #2 rst = 1'b1;
    #1;
    check("R2_out_valid", out_valid, 0);
    check("R2_in_ready", in_ready, 1);
    check("R2_max_val", max_val, 0);
    check("R2_y0", y[0], 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
